// File: rtl/neuron_mac_seq_if.sv
// neuron_mac_seq_if: control handshake, weight-BRAM port and result handshake of one neuron stage
interface neuron_mac_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [DATA_W-1:0] bias;
    logic [DATA_W-1:0] x_data;
    logic              x_valid;
    logic              x_ready;
    logic [ADDR_W-1:0] w_addr;
    logic              w_en;
    logic              w_we;
    logic [DATA_W-1:0] w_do;
    logic [DATA_W-1:0] y_data;
    logic              y_valid;
    logic              y_ready;
    logic              busy;
    modport master (
        output start, bias, x_data, x_valid, w_do, y_ready,
        input  x_ready, w_addr, w_en, w_we, y_data, y_valid, busy
    );
    modport slave (
        input  start, bias, x_data, x_valid, w_do, y_ready,
        output x_ready, w_addr, w_en, w_we, y_data, y_valid, busy
    );
endinterface

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: walks a weight BRAM, MACs streamed activations, adds bias, applies ReLU/saturation
module neuron_mac_seq #(
    parameter int N_INPUTS  = 28,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40,
    parameter int RELU      = 1
) (
    input logic            clk,
    input logic            rst_n,
    neuron_mac_seq_if.slave m
);
    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_BIAS, S_DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_INPUTS - 1);
    state_t                     state, state_nxt;
    logic signed [ACC_W-1:0]    acc, acc_nxt, sum, r;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-DATA_W:0]      hi;
    logic [ADDR_W-1:0]          idx, idx_nxt, w_addr, w_addr_nxt;
    logic [DATA_W-1:0]          bias_q, bias_nxt, y_data, y_data_nxt, sat, y_res;
    logic                       w_en, w_en_nxt, y_valid, y_valid_nxt, hs;

    assign hs   = m.x_valid && state == S_RUN;
    assign prod = $signed(m.x_data) * $signed(m.w_do);
    assign sum  = acc + ($signed({{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q}) <<< FRAC_BITS);
    assign r    = sum >>> FRAC_BITS;
    // r fits DATA_W only when all bits from the output sign bit upward agree
    assign hi    = r[ACC_W-1:DATA_W-1];
    assign sat   = (&hi || ~|hi) ? r[DATA_W-1:0] : {r[ACC_W-1], {(DATA_W-1){~r[ACC_W-1]}}};
    assign y_res = (RELU != 0 && r[ACC_W-1]) ? '0 : sat;

    assign m.x_ready = state == S_RUN;
    assign m.busy    = state != S_IDLE;
    assign m.w_we    = 1'b0;
    assign m.w_addr  = w_addr;
    assign m.w_en    = w_en;
    assign m.y_data  = y_data;
    assign m.y_valid = y_valid;

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        idx_nxt     = idx;
        bias_nxt    = bias_q;
        w_addr_nxt  = w_addr;
        w_en_nxt    = 1'b0;
        y_data_nxt  = y_data;
        y_valid_nxt = y_valid;
        case (state)
            S_IDLE: if (m.start) begin
                bias_nxt   = m.bias;
                acc_nxt    = '0;
                idx_nxt    = '0;
                w_addr_nxt = '0;
                w_en_nxt   = 1'b1;
                state_nxt  = S_PRIME;
            end
            S_PRIME: state_nxt = S_RUN;
            // a stall leaves w_en low so the BRAM keeps presenting W[idx]
            S_RUN: if (hs) begin
                acc_nxt = acc + $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
                if (idx == LAST) begin
                    state_nxt = S_BIAS;
                end else begin
                    idx_nxt    = idx + 1'b1;
                    w_addr_nxt = idx + 1'b1;
                    w_en_nxt   = 1'b1;
                end
            end
            S_BIAS: begin
                y_data_nxt  = y_res;
                y_valid_nxt = 1'b1;
                state_nxt   = S_DONE;
            end
            S_DONE: if (m.y_ready) begin
                y_valid_nxt = 1'b0;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            idx     <= '0;
            bias_q  <= '0;
            w_addr  <= '0;
            w_en    <= 1'b0;
            y_data  <= '0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            idx     <= idx_nxt;
            bias_q  <= bias_nxt;
            w_addr  <= w_addr_nxt;
            w_en    <= w_en_nxt;
            y_data  <= y_data_nxt;
            y_valid <= y_valid_nxt;
        end
    end
endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequencer and multiply-accumulate stage that sits directly downstream of one per-neuron weight BRAM (28 × 16-bit). It walks the BRAM address space and multiplies each weight by one streamed input activation. It accumulates the products, adds a bias, and applies optional ReLU and saturation. It emits one 16-bit neuron output per START.

## Interface
Parameters:
- N_INPUTS, 28, number of weights/activations per neuron (BRAM depth)
- ADDR_W, 5, weight BRAM address width
- DATA_W, 16, weight/activation/bias/output width, signed two's complement
- FRAC_BITS, 8, fractional bits of the fixed-point format (Q7.8)
- ACC_W, 40, accumulator width, signed
- RELU, 1, 1 = clamp negative results to 0; 0 = pass signed result

Ports:
- CLK  in  1  single clock; all logic on posedge
- RST_N  in  1  synchronous, active-low reset
- START  in  1  begin one neuron evaluation; honoured only in IDLE
- BIAS  in  DATA_W  neuron bias (Q7.8); sampled on the cycle START is accepted
- X_DATA  in  DATA_W  input activation (Q7.8)
- X_VALID  in  1  X_DATA valid
- X_READY  out  1  block accepts X_DATA this cycle
- W_ADDR  out  ADDR_W  weight BRAM address (registered)
- W_EN  out  1  weight BRAM enable (registered)
- W_WE  out  1  weight BRAM write enable; constant 0
- W_DO  in  DATA_W  weight BRAM read data
- Y_DATA  out  DATA_W  neuron result (Q7.8)
- Y_VALID  out  1  Y_DATA valid
- Y_READY  in  1  consumer accepts Y_DATA
- BUSY  out  1  high in every state except IDLE

## Operation
- States: IDLE, PRIME, RUN, BIAS, DONE.
- IDLE, on START: latch BIAS, clear accumulator, set idx=0. Register W_EN=1 and W_ADDR=0. Go to PRIME.
- PRIME: register W_EN=0. Go to RUN. W_DO holds W[0] by the next posedge; the BRAM updates DO on the negedge of the PRIME cycle.
- RUN: X_READY=1 (combinational from state).
  - On handshake (X_VALID & X_READY): acc += sign-extended (X_DATA × W_DO), a 32-bit signed product extended to ACC_W.
  - If idx < N_INPUTS-1: idx+1, register W_EN=1 and W_ADDR=idx+1. The next weight is present at the following posedge, so a handshake every cycle is allowed.
  - If idx = N_INPUTS-1: register W_EN=0 and go to BIAS.
  - No handshake: register W_EN=0. The BRAM holds DO while EN is low, so W_DO stays equal to W[idx] for any stall length.
- BIAS:
  - r = (acc + (sign-extended bias << FRAC_BITS)) >>> FRAC_BITS. This is an arithmetic shift that truncates toward −∞.
  - Saturate r to [−32768, 32767]. If RELU=1 and r<0, set r=0.
  - Register Y_DATA=r and Y_VALID=1. Go to DONE.
- DONE: hold Y_DATA and Y_VALID until Y_READY=1. On Y_READY, clear Y_VALID and go to IDLE. START is ignored until IDLE is reached.
- START outside IDLE is ignored. X_DATA presented outside RUN is not consumed.
- Accumulator headroom: 28 × max |product| (2^30) < 2^39, so the accumulator never overflows; saturation occurs only at output.

## Timing
- Reset (RST_N=0 at posedge): state=IDLE, acc=0, idx=0. Outputs: W_ADDR=0, W_EN=0, W_WE=0, Y_DATA=0, Y_VALID=0, X_READY=0, BUSY=0.
- Reset mid-operation aborts immediately. No partial result is emitted, and the first evaluation after reset starts clean.
- START sampled at posedge 0: PRIME during cycle 1, RUN from cycle 2.
- With X_VALID held high, the 28 handshakes occur at posedges 2..29, BIAS is cycle 30, and Y_VALID rises after posedge 30. Total latency is N_INPUTS+3 cycles.
- Each X_VALID low cycle in RUN adds exactly one cycle of latency.
- W_ADDR is never ≥ N_INPUTS. W_EN pulses at most N_INPUTS times per evaluation.
- Y_READY=1 already high when Y_VALID rises: the transfer completes at that posedge. IDLE is entered the next cycle, and START is honoured there. Back-to-back period is N_INPUTS+4 cycles.

## Test plan
- BRAM model loaded with all weights 0x0100 (1.0), X_DATA=0x0100 every cycle, BIAS=0 → Y_DATA=0x1C00 (28.0). Y_VALID rises exactly 31 cycles after START; W_EN pulses 28 times with W_ADDR 0..27.
- Weights 0x7FFF, X_DATA=0x7FFF, BIAS=0x7FFF → Y_DATA=0x7FFF (positive saturation). With RELU=0, weights 0x8000 and X=0x7FFF → Y_DATA=0x8000 (negative saturation).
- Weights 0x0100, X_DATA=0xFF00 (−1.0), BIAS=0x0080 (0.5) → RELU=0 gives 0xE480 (−27.5); RELU=1 gives 0x0000.
- Weights W[i]=i×0x0100, X=0x0100, with X_VALID low on random cycles (including 5 consecutive after idx=13). Expected Y_DATA=0x7FFF, since the 378.0 sum saturates; the bench compares the internal acc to 378×65536. W_DO must equal W[idx] at every handshake, and latency = 31 + idle cycles.
- Y_READY held low 10 cycles in DONE → Y_DATA/Y_VALID stable. A START pulse during DONE is ignored, and a START one cycle after Y_READY begins a new run.
- RST_N low for one cycle at idx=15 → all outputs at reset values next cycle, no Y_VALID. A subsequent clean run reproduces the scenario-1 result.
